aes_encipher_block_p: RTL and testbench

Parametrised iterative AES encipher datapath (FIPS-197) for 128-, 192- and 256-bit keys. SubBytes throughput is configurable at 1, 2 or 4 32-bit words per cycle.
Sits between the AES core control and the shared S-box array and key-memory blocks. It requests a round key by round index and sends words to external S-boxes.

---
 rtl/aes_pkg.sv | 77 +++++++
 rtl/aes_encipher_block_p_if.sv | 29 ++
 rtl/aes_enc_sbox_mux.sv | 28 ++
 rtl/aes_encipher_block_p.sv | 145 ++++++++++++++
 tb/tb_aes_encipher_block_p.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length codes, round counts, FSM encoding and
// the byte/word/state transforms used by the encipher and decipher blocks.
package aes_pkg;

  localparam logic [1:0] KEYLEN_128 = 2'b00;
  localparam logic [1:0] KEYLEN_256 = 2'b01;
  localparam logic [1:0] KEYLEN_192 = 2'b10;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_SBOX = 2'd2,
    ST_MAIN = 2'd3
  } aes_state_e;

  // Round count for a key-length code; the reserved code behaves as AES-128.
  function automatic logic [3:0] nr_for_keylen(input logic [1:0] keylen);
    case (keylen)
      KEYLEN_256: nr_for_keylen = NR_256;
      KEYLEN_192: nr_for_keylen = NR_192;
      default:    nr_for_keylen = NR_128;
    endcase
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gm2(input logic [7:0] b);
    gm2 = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm3(input logic [7:0] b);
    gm3 = gm2(b) ^ b;
  endfunction

  // MixColumns on one column; row 0 sits in the MSB byte.
  function automatic logic [31:0] mixw(input logic [31:0] w);
    logic [7:0] b0, b1, b2, b3;
    b0 = w[31:24];
    b1 = w[23:16];
    b2 = w[15:8];
    b3 = w[7:0];
    mixw = {gm2(b0) ^ gm3(b1) ^ b2      ^ b3,
            b0      ^ gm2(b1) ^ gm3(b2) ^ b3,
            b0      ^ b1      ^ gm2(b2) ^ gm3(b3),
            gm3(b0) ^ b1      ^ b2      ^ gm2(b3)};
  endfunction

  function automatic logic [127:0] mixcolumns(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      r[127-32*c -: 32] = mixw(s[127-32*c -: 32]);
    end
    mixcolumns = r;
  endfunction

  // Row r of the state rotates left by r columns; each 32-bit word is a column.
  function automatic logic [127:0] shiftrows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c+row)%4)+row) -: 8];
      end
    end
    shiftrows = r;
  endfunction

  function automatic logic [127:0] addroundkey(input logic [127:0] s,
                                               input logic [127:0] k);
    addroundkey = s ^ k;
  endfunction

endpackage

// File: rtl/aes_encipher_block_p_if.sv
// Connection bundle between the AES core control / S-box array / key memory
// (master side) and the encipher datapath (slave side).
interface aes_encipher_block_p_if #(
  parameter int NUM_SBOX_WORDS = 1
);

  logic                          next;
  logic                          abort;
  logic [1:0]                    keylen;
  logic [3:0]                    round;
  logic [127:0]                  round_key;
  logic [32*NUM_SBOX_WORDS-1:0]  sboxw;
  logic [32*NUM_SBOX_WORDS-1:0]  new_sboxw;
  logic [127:0]                  block;
  logic [127:0]                  new_block;
  logic                          ready;
  logic                          done;

  modport master (
    output next, abort, keylen, round_key, new_sboxw, block,
    input  round, sboxw, new_block, ready, done
  );

  modport slave (
    input  next, abort, keylen, round_key, new_sboxw, block,
    output round, sboxw, new_block, ready, done
  );

endinterface

// File: rtl/aes_enc_sbox_mux.sv
// Lane selection for the shared S-boxes: picks NUM_SBOX_WORDS state words by
// sword_ctr, presents them on sboxw and merges the substituted words back.
module aes_enc_sbox_mux #(
  parameter int NUM_SBOX_WORDS = 1
) (
  input  logic                          active,
  input  logic [1:0]                    sword_ctr,
  input  logic [127:0]                  state_in,
  input  logic [32*NUM_SBOX_WORDS-1:0]  new_sboxw,
  output logic [32*NUM_SBOX_WORDS-1:0]  sboxw,
  output logic [127:0]                  state_out
);

  // Lane i carries word sword_ctr*NUM_SBOX_WORDS+i; word 0 is the state MSBs.
  always_comb begin
    sboxw     = '0;
    state_out = state_in;
    if (active) begin
      for (int i = 0; i < NUM_SBOX_WORDS; i++) begin
        sboxw[32*(NUM_SBOX_WORDS-1-i) +: 32] =
          state_in[32*(3 - (int'(sword_ctr)*NUM_SBOX_WORDS + i)) +: 32];
        state_out[32*(3 - (int'(sword_ctr)*NUM_SBOX_WORDS + i)) +: 32] =
          new_sboxw[32*(NUM_SBOX_WORDS-1-i) +: 32];
      end
    end
  end

endmodule

// File: rtl/aes_encipher_block_p.sv
// Iterative AES encipher datapath for 128/192/256-bit keys. Round keys come
// from external key memory by round index; SubBytes uses external S-boxes,
// NUM_SBOX_WORDS words per cycle.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready high; waits for next (without abort), latches keylen
// INIT  | initial AddRoundKey with round key 0
// SBOX  | SubBytes, one group of NUM_SBOX_WORDS words per cycle
// MAIN  | ShiftRows/MixColumns/AddRoundKey; final round skips MixColumns
module aes_encipher_block_p
#(
  parameter int NUM_SBOX_WORDS = 1
) (
  input logic                   clk,
  input logic                   reset_n,
  aes_encipher_block_p_if.slave bus
);

  import aes_pkg::*;

  if (!(NUM_SBOX_WORDS == 1 || NUM_SBOX_WORDS == 2 || NUM_SBOX_WORDS == 4)) begin : g_bad_width
    $error("aes_encipher_block_p: NUM_SBOX_WORDS must be 1, 2 or 4");
  end

  localparam int         SBOX_CYCLES = 4 / NUM_SBOX_WORDS;
  localparam logic [1:0] SWORD_LAST  = 2'(SBOX_CYCLES - 1);

  aes_state_e   state_q, state_d;
  logic [127:0] block_q, block_d;
  logic [127:0] sbox_block;
  logic [3:0]   round_q, round_d;
  logic [3:0]   nr;
  logic [1:0]   sword_ctr_q, sword_ctr_d;
  logic [1:0]   keylen_q, keylen_d;
  logic         ready_q, ready_d;
  logic         done_q, done_d;
  logic         sbox_active;

  assign nr          = nr_for_keylen(keylen_q);
  assign sbox_active = (state_q == ST_SBOX);

  aes_enc_sbox_mux #(
    .NUM_SBOX_WORDS (NUM_SBOX_WORDS)
  ) u_sbox_mux (
    .active    (sbox_active),
    .sword_ctr (sword_ctr_q),
    .state_in  (block_q),
    .new_sboxw (bus.new_sboxw),
    .sboxw     (bus.sboxw),
    .state_out (sbox_block)
  );

  // Next-state, round math and handshake outputs.
  always_comb begin
    state_d     = state_q;
    block_d     = block_q;
    round_d     = round_q;
    sword_ctr_d = sword_ctr_q;
    keylen_d    = keylen_q;
    ready_d     = ready_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.next && !bus.abort) begin
          round_d  = 4'd0;
          ready_d  = 1'b0;
          keylen_d = bus.keylen;
          state_d  = ST_INIT;
        end
      end

      ST_INIT: begin
        block_d     = addroundkey(bus.block, bus.round_key);
        round_d     = 4'd1;
        sword_ctr_d = 2'd0;
        state_d     = ST_SBOX;
      end

      ST_SBOX: begin
        block_d = sbox_block;
        if (sword_ctr_q == SWORD_LAST) begin
          sword_ctr_d = 2'd0;
          state_d     = ST_MAIN;
        end else begin
          sword_ctr_d = sword_ctr_q + 2'd1;
        end
      end

      ST_MAIN: begin
        if (round_q < nr) begin
          block_d = addroundkey(mixcolumns(shiftrows(block_q)), bus.round_key);
          round_d = round_q + 4'd1;
          state_d = ST_SBOX;
        end else begin
          block_d = addroundkey(shiftrows(block_q), bus.round_key);
          ready_d = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Abort beats everything, including the final round: the partial state
    // and round index are left visible, no done pulse.
    if (bus.abort && state_q != ST_IDLE) begin
      state_d     = ST_IDLE;
      block_d     = block_q;
      round_d     = round_q;
      sword_ctr_d = 2'd0;
      ready_d     = 1'b1;
      done_d      = 1'b0;
    end
  end

  // State, datapath and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      block_q     <= '0;
      round_q     <= '0;
      sword_ctr_q <= '0;
      keylen_q    <= KEYLEN_128;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      block_q     <= block_d;
      round_q     <= round_d;
      sword_ctr_q <= sword_ctr_d;
      keylen_q    <= keylen_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
    end
  end

  assign bus.round     = round_q;
  assign bus.new_block = block_q;
  assign bus.ready     = ready_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_aes_encipher_block_p.sv
// Bench: three encipher instances (1, 2 and 4 S-box words per cycle) driven
// with the same vectors, fed by a reference key expansion and S-box model.
module tb_aes_encipher_block_p;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic         next_v  [3];
  logic         abort_v [3];
  logic [1:0]   keylen_v;
  logic [127:0] block_v;
  logic [127:0] rk [0:15];
  logic [127:0] exp_ct;

  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT2  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT3  = 128'h8ea2b7ca516745bfeafc49904b496089;

  // ---------------- reference GF/S-box/key expansion ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // Inverse as a^254, then the FIPS-197 affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] t = a;
    logic [7:0] r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      t = gmul(t, t);
      r = gmul(r, t);
    end
    return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  task automatic expand(input logic [255:0] key, input int nk);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    int nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      if (r <= nr) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else         rk[r] = '0;
    end
  endtask

  // ---------------- DUTs ----------------
  aes_encipher_block_p_if #(.NUM_SBOX_WORDS(1)) bus1 ();
  aes_encipher_block_p_if #(.NUM_SBOX_WORDS(2)) bus2 ();
  aes_encipher_block_p_if #(.NUM_SBOX_WORDS(4)) bus4 ();

  aes_encipher_block_p #(.NUM_SBOX_WORDS(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
  aes_encipher_block_p #(.NUM_SBOX_WORDS(2)) dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2));
  aes_encipher_block_p #(.NUM_SBOX_WORDS(4)) dut4 (.clk(clk), .reset_n(reset_n), .bus(bus4));

  assign bus1.next = next_v[0];  assign bus1.abort = abort_v[0];
  assign bus2.next = next_v[1];  assign bus2.abort = abort_v[1];
  assign bus4.next = next_v[2];  assign bus4.abort = abort_v[2];
  assign bus1.keylen = keylen_v; assign bus2.keylen = keylen_v; assign bus4.keylen = keylen_v;
  assign bus1.block  = block_v;  assign bus2.block  = block_v;  assign bus4.block  = block_v;
  assign bus1.round_key = rk[bus1.round];
  assign bus2.round_key = rk[bus2.round];
  assign bus4.round_key = rk[bus4.round];
  assign bus1.new_sboxw = sub_word(bus1.sboxw);
  assign bus2.new_sboxw = {sub_word(bus2.sboxw[63:32]), sub_word(bus2.sboxw[31:0])};
  assign bus4.new_sboxw = {sub_word(bus4.sboxw[127:96]), sub_word(bus4.sboxw[95:64]),
                           sub_word(bus4.sboxw[63:32]),  sub_word(bus4.sboxw[31:0])};

  logic         ready_a [3];
  logic         done_a  [3];
  logic         sboxz_a [3];
  logic [3:0]   round_a [3];
  logic [127:0] nb_a    [3];
  assign ready_a[0] = bus1.ready; assign ready_a[1] = bus2.ready; assign ready_a[2] = bus4.ready;
  assign done_a[0]  = bus1.done;  assign done_a[1]  = bus2.done;  assign done_a[2]  = bus4.done;
  assign round_a[0] = bus1.round; assign round_a[1] = bus2.round; assign round_a[2] = bus4.round;
  assign nb_a[0] = bus1.new_block; assign nb_a[1] = bus2.new_block; assign nb_a[2] = bus4.new_block;
  assign sboxz_a[0] = (bus1.sboxw == '0);
  assign sboxz_a[1] = (bus2.sboxw == '0);
  assign sboxz_a[2] = (bus4.sboxw == '0);

  task automatic chk(input string nm, input int k, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[dut%0d]: got %h, expected %h", nm, k, act, exp);
    end
  endtask

  // ---------------- timing model ----------------
  // An accepted start occupies 2 + Nr*(S+1) edges (start edge included);
  // abort while busy returns to idle on that edge without a done pulse.
  int   s_cyc [3] = '{4, 2, 1};
  bit   m_busy  [3];
  bit   m_ready [3];
  bit   m_done  [3];
  int   m_edges [3];
  int   m_nr    [3];

  always @(posedge clk or negedge reset_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!reset_n) begin
        m_busy[k] = 0; m_ready[k] = 1; m_done[k] = 0; m_edges[k] = 0; m_nr[k] = 10;
      end else begin
        m_done[k] = 0;
        if (!m_busy[k]) begin
          if (next_v[k] && !abort_v[k]) begin
            m_busy[k]  = 1;
            m_ready[k] = 0;
            m_edges[k] = 1;
            m_nr[k]    = (keylen_v == 2'b01) ? 14 : (keylen_v == 2'b10) ? 12 : 10;
          end
        end else if (abort_v[k]) begin
          m_busy[k]  = 0;
          m_ready[k] = 1;
        end else begin
          m_edges[k]++;
          if (m_edges[k] == 2 + m_nr[k]*(s_cyc[k]+1)) begin
            m_busy[k] = 0; m_ready[k] = 1; m_done[k] = 1;
          end
        end
      end
    end
  end

  int lat      [3];
  int done_cnt [3];

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk("ready", k, 128'(ready_a[k]), 128'(m_ready[k]));
      chk("done",  k, 128'(done_a[k]),  128'(m_done[k]));
      if (m_ready[k]) chk("sboxw_idle", k, 128'(sboxz_a[k]), 128'd1);
      if (m_done[k]) begin
        chk("ciphertext", k, nb_a[k], exp_ct);
        chk("round_at_done", k, 128'(round_a[k]), 128'(m_nr[k]));
      end
      if (!ready_a[k]) lat[k]++;
      if (done_a[k])   done_cnt[k]++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_next();
    for (int k = 0; k < 3; k++) next_v[k] = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) next_v[k] = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    bit all_rdy = 0;
    for (int c = 0; c < 300 && !all_rdy; c++) begin
      tick();
      all_rdy = ready_a[0] && ready_a[1] && ready_a[2];
    end
    chk(nm, 0, 128'(all_rdy), 128'd1);
  endtask

  task automatic setup(input logic [255:0] key, input int nk, input logic [1:0] kl,
                       input logic [127:0] ct);
    expand(key, nk);
    keylen_v = kl;
    block_v  = PT;
    exp_ct   = ct;
  endtask

  task automatic run_case(input string nm, input logic [255:0] key, input int nk,
                          input logic [1:0] kl, input logic [127:0] ct,
                          input int l0, input int l1, input int l2, input bit flip_keylen);
    int base [3];
    int lexp [3];
    lexp = '{l0, l1, l2};
    setup(key, nk, kl, ct);
    for (int k = 0; k < 3; k++) begin base[k] = done_cnt[k]; lat[k] = 0; end
    pulse_next();
    if (flip_keylen) begin
      repeat (6) tick();
      keylen_v = 2'b00;
    end
    wait_idle({nm, "_timeout"});
    tick();
    for (int k = 0; k < 3; k++) begin
      chk({nm, "_ct"}, k, nb_a[k], ct);
      chk({nm, "_done_pulses"}, k, 128'(done_cnt[k] - base[k]), 128'd1);
      chk({nm, "_latency"}, k, 128'(lat[k] + 1), 128'(lexp[k]));
    end
  endtask

  initial begin
    int base [3];
    bit ab   [3];
    bit busy;

    for (int k = 0; k < 3; k++) begin next_v[k] = 0; abort_v[k] = 0; lat[k] = 0; done_cnt[k] = 0; end
    keylen_v = 2'b00;
    block_v  = '0;
    exp_ct   = '0;
    for (int r = 0; r < 16; r++) rk[r] = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      chk("rst_new_block", k, nb_a[k], '0);
      chk("rst_round", k, 128'(round_a[k]), '0);
      chk("rst_ready", k, 128'(ready_a[k]), 128'd1);
      chk("rst_done",  k, 128'(done_a[k]), '0);
    end
    reset_n = 1'b1;
    tick();

    run_case("c1_aes128", K128, 4, 2'b00, CT1, 52, 32, 22, 0);
    run_case("c2_aes192", K192, 6, 2'b10, CT2, 62, 38, 26, 0);
    run_case("c3_aes256", K256, 8, 2'b01, CT3, 72, 44, 30, 1);
    run_case("reserved_keylen", K128, 4, 2'b11, CT1, 52, 32, 22, 0);

    // Abort each instance during its round-5 SBOX phase.
    setup(K128, 4, 2'b00, CT1);
    for (int k = 0; k < 3; k++) begin base[k] = done_cnt[k]; ab[k] = 0; end
    pulse_next();
    busy = 1;
    for (int c = 0; c < 300 && busy; c++) begin
      tick();
      busy = 0;
      for (int k = 0; k < 3; k++) begin
        if (abort_v[k]) begin
          chk("abort_ready", k, 128'(ready_a[k]), 128'd1);
          chk("abort_round_hold", k, 128'(round_a[k]), 128'd5);
          abort_v[k] = 0;
        end else if (!ab[k] && !ready_a[k] && round_a[k] == 4'd5) begin
          abort_v[k] = 1;
          ab[k] = 1;
        end
        if (!ab[k] || abort_v[k]) busy = 1;
      end
    end
    repeat (4) tick();
    for (int k = 0; k < 3; k++) begin
      chk("abort_issued", k, 128'(ab[k]), 128'd1);
      chk("abort_no_done", k, 128'(done_cnt[k] - base[k]), '0);
    end
    run_case("after_abort", K128, 4, 2'b00, CT1, 52, 32, 22, 0);

    // next held high for the whole operation: exactly one start.
    for (int k = 0; k < 3; k++) begin base[k] = done_cnt[k]; next_v[k] = 1'b1; end
    busy = 1;
    for (int c = 0; c < 300 && busy; c++) begin
      tick();
      busy = 0;
      for (int k = 0; k < 3; k++) begin
        if (done_a[k]) next_v[k] = 1'b0;
        if (next_v[k]) busy = 1;
      end
    end
    repeat (4) tick();
    for (int k = 0; k < 3; k++) begin
      chk("held_next_done", k, 128'(done_cnt[k] - base[k]), 128'd1);
      chk("held_next_ct", k, nb_a[k], CT1);
    end

    // next together with abort in IDLE must not start.
    for (int k = 0; k < 3; k++) begin base[k] = done_cnt[k]; next_v[k] = 1; abort_v[k] = 1; end
    tick();
    for (int k = 0; k < 3; k++) begin next_v[k] = 0; abort_v[k] = 0; end
    for (int k = 0; k < 3; k++) chk("abort_next_idle", k, 128'(ready_a[k]), 128'd1);
    repeat (60) tick();
    for (int k = 0; k < 3; k++) chk("abort_next_no_done", k, 128'(done_cnt[k] - base[k]), '0);

    // Asynchronous reset between edges mid-run.
    pulse_next();
    repeat (15) tick();
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("midrst_new_block", k, nb_a[k], '0);
      chk("midrst_ready", k, 128'(ready_a[k]), 128'd1);
      chk("midrst_round", k, 128'(round_a[k]), '0);
    end
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    run_case("after_reset", K128, 4, 2'b00, CT1, 52, 32, 22, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
